// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite responder in front of a bank of 32-bit control/status registers.
// Independent write (AW+W -> B) and read (AR -> R) engines; each holds one transaction.
module axi_lite_slave_regs #(
  parameter int unsigned         NUM_REGS  = 16,
  parameter logic [31:0]         BASE_ADDR = 32'h0000_0000,
  parameter logic [NUM_REGS-1:0] RO_MASK   = {NUM_REGS{1'b0}}
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [32*NUM_REGS-1:0]   reg_out,
  input  logic [32*NUM_REGS-1:0]   status_in,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int unsigned IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] SPAN        = 32'(4 * NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  function automatic logic in_range_f(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] index_f(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  wstate_e                    wstate_r, wstate_s;
  rstate_e                    rstate_r, rstate_s;
  logic                       aw_got_r, aw_got_s, w_got_r, w_got_s;
  logic [31:0]                awaddr_r, awaddr_s, wdata_r, wdata_s;
  logic [3:0]                 wstrb_r, wstrb_s;
  logic                       awready_r, awready_s, wready_r, wready_s;
  logic                       bvalid_r, bvalid_s;
  logic [1:0]                 bresp_r, bresp_s;
  logic [NUM_REGS-1:0]        wr_pulse_r, wr_pulse_s;
  logic [NUM_REGS-1:0][31:0]  regs_r, regs_s;
  logic                       arready_r, arready_s, rvalid_r, rvalid_s;
  logic [31:0]                rdata_r, rdata_s;
  logic [1:0]                 rresp_r, rresp_s;
  logic [NUM_REGS-1:0][31:0]  status_words_s;
  logic                       aw_hs_s, w_hs_s, ar_hs_s;
  logic [IDX_W-1:0]           w_idx_s, r_idx_s;
  logic                       unused_prot_s;

  assign status_words_s = status_in;
  assign unused_prot_s  = ^{awprot, arprot};
  assign aw_hs_s        = awvalid & awready_r;
  assign w_hs_s         = wvalid & wready_r;
  assign ar_hs_s        = arvalid & arready_r;
  // A channel captured on this very edge is used directly so same-cycle AW+W commits at once.
  assign awaddr_s       = aw_hs_s ? awaddr : awaddr_r;
  assign wdata_s        = w_hs_s ? wdata : wdata_r;
  assign wstrb_s        = w_hs_s ? wstrb : wstrb_r;
  assign w_idx_s        = index_f(awaddr_s);
  assign r_idx_s        = index_f(araddr);

  // Write engine: channel capture, commit with byte strobes, B response.
  always_comb begin
    wstate_s   = wstate_r;
    aw_got_s   = aw_got_r;
    w_got_s    = w_got_r;
    awready_s  = awready_r;
    wready_s   = wready_r;
    bvalid_s   = bvalid_r;
    bresp_s    = bresp_r;
    wr_pulse_s = {NUM_REGS{1'b0}};
    regs_s     = regs_r;
    case (wstate_r)
      W_IDLE: begin
        if ((aw_got_r | aw_hs_s) && (w_got_r | w_hs_s)) begin
          wstate_s  = W_RESP;
          aw_got_s  = 1'b0;
          w_got_s   = 1'b0;
          awready_s = 1'b0;
          wready_s  = 1'b0;
          bvalid_s  = 1'b1;
          if (!in_range_f(awaddr_s)) begin
            bresp_s = RESP_DECERR;
          end else if (RO_MASK[w_idx_s]) begin
            bresp_s = RESP_SLVERR;
          end else begin
            bresp_s             = RESP_OKAY;
            wr_pulse_s[w_idx_s] = 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (wstrb_s[b]) begin
                regs_s[w_idx_s][8*b +: 8] = wdata_s[8*b +: 8];
              end else begin
                regs_s[w_idx_s][8*b +: 8] = regs_r[w_idx_s][8*b +: 8];
              end
            end
          end
        end else begin
          aw_got_s  = aw_got_r | aw_hs_s;
          w_got_s   = w_got_r | w_hs_s;
          awready_s = ~(aw_got_r | aw_hs_s);
          wready_s  = ~(w_got_r | w_hs_s);
        end
      end
      W_RESP: begin
        if (bready) begin
          wstate_s  = W_IDLE;
          bvalid_s  = 1'b0;
          awready_s = 1'b1;
          wready_s  = 1'b1;
        end else begin
          wstate_s  = W_RESP;
        end
      end
      default: begin
        wstate_s = W_IDLE;
      end
    endcase
  end

  // Read engine: sample the bank at the AR handshake, hold R until accepted.
  always_comb begin
    rstate_s  = rstate_r;
    arready_s = arready_r;
    rvalid_s  = rvalid_r;
    rdata_s   = rdata_r;
    rresp_s   = rresp_r;
    case (rstate_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          rstate_s  = R_DATA;
          arready_s = 1'b0;
          rvalid_s  = 1'b1;
          if (!in_range_f(araddr)) begin
            rdata_s = 32'h0000_0000;
            rresp_s = RESP_DECERR;
          end else if (RO_MASK[r_idx_s]) begin
            rdata_s = status_words_s[r_idx_s];
            rresp_s = RESP_OKAY;
          end else begin
            rdata_s = regs_r[r_idx_s];
            rresp_s = RESP_OKAY;
          end
        end else begin
          arready_s = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          rstate_s  = R_IDLE;
          rvalid_s  = 1'b0;
          arready_s = 1'b1;
        end else begin
          rstate_s  = R_DATA;
        end
      end
      default: begin
        rstate_s = R_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_r   <= W_IDLE;
      rstate_r   <= R_IDLE;
      aw_got_r   <= 1'b0;
      w_got_r    <= 1'b0;
      awaddr_r   <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      wstrb_r    <= 4'h0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= 2'b00;
      wr_pulse_r <= {NUM_REGS{1'b0}};
      regs_r     <= {(32*NUM_REGS){1'b0}};
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      rresp_r    <= 2'b00;
    end else begin
      wstate_r   <= wstate_s;
      rstate_r   <= rstate_s;
      aw_got_r   <= aw_got_s;
      w_got_r    <= w_got_s;
      awaddr_r   <= awaddr_s;
      wdata_r    <= wdata_s;
      wstrb_r    <= wstrb_s;
      awready_r  <= awready_s;
      wready_r   <= wready_s;
      bvalid_r   <= bvalid_s;
      bresp_r    <= bresp_s;
      wr_pulse_r <= wr_pulse_s;
      regs_r     <= regs_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      rdata_r    <= rdata_s;
      rresp_r    <= rresp_s;
    end
  end

  assign awready  = awready_r;
  assign wready   = wready_r;
  assign bvalid   = bvalid_r;
  assign bresp    = bresp_r;
  assign wr_pulse = wr_pulse_r;
  assign arready  = arready_r;
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign rresp    = rresp_r;
  assign reg_out  = regs_r;

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
Synthesizable AXI-Lite slave (responder) fronting a bank of 32-bit control/status registers. It is the RTL counterpart of the axi_lite_if master-side tasks and uses the same 32-bit address/data, 3-bit prot and 2-bit resp channel signals. Read-write registers drive fabric logic through a flat output bus. Read-only registers sample fabric status inputs.

Parameters:
NUM_REGS, 16, number of 32-bit registers (1..64)
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be 4*NUM_REGS-aligned
RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only (reads return status_in word i)

Ports:
aclk  input  1  clock; all logic on rising edge
aresetn  input  1  asynchronous active-low reset
awaddr  input  32  write address
awprot  input  3  ignored
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  32  write data
wstrb  input  4  byte-lane enables
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response
bvalid  output  1  write response valid
bready  input  1  write response ready
araddr  input  32  read address
arprot  input  3  ignored
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  32  read data
rresp  output  2  read response
rvalid  output  1  read data valid
rready  input  1  read data ready
reg_out  output  32*NUM_REGS  RW register contents; word i = bits [32i+31:32i]
status_in  input  32*NUM_REGS  RO register sources; only RO_MASK words are used
wr_pulse  output  NUM_REGS  one-cycle strobe per successfully written register

Behaviour:
- Reset (async assert, sync release): all registers 0. awready, wready, bvalid, arready, rvalid and wr_pulse are 0. bresp, rresp and rdata are 0. From the first clock after release, awready=wready=arready=1.
- Decode: byte offset = addr - BASE_ADDR. Index = offset[...:2]; addr[1:0] ignored. In range iff BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS.
- Write FSM: W_IDLE, W_RESP.
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle. On each handshake the address/data+strb are latched, and that channel's ready drops to 0 until the B handshake completes.
  - On the edge where the second of the two is captured (both flags set): commit the write, set bvalid=1 with bresp, go to W_RESP. Result: bvalid rises 1 cycle after the later of the AW/W handshakes.
  - Commit: OKAY (2'b00) writes bytes whose wstrb bit is set; other bytes are unchanged. wstrb=0 is OKAY with no change. RO index gives SLVERR (2'b10) with no change. Out of range gives DECERR (2'b11) with no change.
  - wr_pulse[i]=1 for exactly the cycle bvalid first rises, only for OKAY writes, including wstrb=0.
  - W_RESP: bvalid and bresp are held stable until bready=1 at a rising edge. On that edge bvalid=0, awready=wready=1, and the FSM returns to W_IDLE. Back-to-back AW/W can be accepted the next cycle.
- Read FSM: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On the AR handshake: arready=0, rvalid=1 next edge, with rdata/rresp computed from araddr at the handshake edge.
  - rdata source: RW index gives register contents, including bytes unaffected by wstrb. RO index gives status_in word. Out of range gives rdata=0, rresp=DECERR. Otherwise rresp=OKAY.
  - R_DATA: rvalid, rdata and rresp are held stable until rready=1 at an edge. Then rvalid=0 and arready=1.
- Read/write collision: read and write channels are fully independent. If an AR handshake and a write commit occur on the same edge to the same register, the read returns the pre-write value.
- Protocol rules: valid outputs never wait on ready inputs. Once bvalid/rvalid is asserted it is not withdrawn before the handshake. Ready may be held high early by the master. The slave holds at most one write and one read outstanding.
- Reset mid-transaction: aresetn low aborts any transaction in flight. No B or R beat is issued for it, and registers clear.

Test Plan:
- Reset, then AW=BASE+8 and W=32'hDEAD_BEEF with strb 4'hF in the same cycle -> bvalid 1 cycle later with bresp=00; reg_out word2=DEADBEEF; wr_pulse[2] high for 1 cycle. Then read BASE+8 -> rdata=DEADBEEF, rresp=00.
- W handshake 3 cycles before AW for index 1 with data 32'h1122_3344 and strb 4'b0101 on a reg holding 32'hFFFF_FFFF -> wready low until B completes; result 32'hFF22_FF44.
- Write and read at BASE+4*NUM_REGS -> bresp=11 and rresp=11 with rdata=0; no register changes; wr_pulse stays 0.
- RO_MASK bit3=1 with status_in word3=32'hCAFE_0001: write index 3 -> bresp=10 and the register is unchanged; read index 3 -> CAFE0001 and rresp=00.
- Hold bready=0 for 5 cycles and rready=0 for 5 cycles -> bvalid, bresp, rvalid and rdata stay stable; awready, wready and arready stay 0 throughout.
- Same-edge AR and write commit to index 0 (old value 5, new value 9) -> rdata=5. Then assert aresetn low during W_RESP -> bvalid=0 immediately, all regs 0, and no B beat after release.
